issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Issue-stage scheduler between the decode unit and the execute unit. Accepts decoded instructions from decode and holds each in a single registered issue slot. Tracks outstanding register writes per architectural register (RV32E, x1–x15) and stalls decode on read-after-write hazards or when a destination's counter is saturated. Releases registers on execute/writeback retirement.

## Interface
- Parameters:
  - `PENDING_W`, default 2: width of the per-register outstanding-write counter. Maximum in flight per register is 2^PENDING_W−1.
- Ports:
  - `clock`  in  1  sole clock; all state updates on its rising edge.
  - `reset`  in  1  asynchronous, active-low reset.
  - `from_decode`  skid_buffer_port.upstream  –  decoded instruction in: valid/ready/data. Data carries instruction, destination, operand_1, operand_2, immediate.
  - `to_execute`  skid_buffer_port.downstream  –  issued instruction out; same payload, unmodified.
  - `flush`  in  1  discard the issue-slot contents; counters unaffected.
  - `wb_valid`  in  1  one register write retired this cycle.
  - `wb_register`  in  4  register index retired; index 0 ignored.
  - `pending_any`  out  1  any counter nonzero or issue slot valid; used for fence/drain.

## Operation
- Per-instruction register usage comes from package function `uses_of(instruction_kind)`, which returns `{reads_rs1, reads_rs2, writes_rd}`. NOP uses nothing. Register fields use bits [3:0].
- `hazard` = (reads_rs1 && rs1≠0 && cnt[rs1]≠0) || (reads_rs2 && rs2≠0 && cnt[rs2]≠0) || (writes_rd && rd≠0 && cnt[rd] = max).
- Issue slot: `slot_valid` plus a data register.
- `from_decode.ready` = !hazard && !flush && (!slot_valid || to_execute.ready). This is combinational.
- Accept: `from_decode.valid && from_decode.ready` loads the slot and increments cnt[rd] if writes_rd and rd≠0.
- Drain: `to_execute.valid` = slot_valid. A transfer clears the slot unless a new accept occurs in the same cycle.
- Counter update each edge: +1 on accept-write, −1 on wb_valid (rd≠0).
  - Both on the same register in the same cycle: net unchanged.
  - Decrement of an already-zero counter: counter stays 0 and `` `LOG `` reports an error.
- Flush: slot_valid ← 0 and no accept that cycle. The flushed instruction's cnt increment, made at its accept, is undone by decrementing cnt[slot.rd] if the slot held a writing instruction.
  - Flush, undo decrement and wb decrement on the same register in one cycle: net −2.
- Register 0 is never counted and never hazards.

## Timing
- Reset values: slot_valid 0, to_execute.valid 0, all counters 0, pending_any 0. from_decode.ready is 1 after reset (no hazard).
- Latency: an instruction accepted at edge N has to_execute.valid high from after N until the transfer edge. Throughput is one per cycle when there are no hazards and execute is ready.
- A dependent instruction is accepted at the earliest on the edge after the producer's wb_valid edge.
- Back-pressure: while to_execute.ready=0 the slot data is stable and from_decode.ready=0.
- Reset asserted mid-operation clears the slot and counters immediately (asynchronous). In-flight writebacks afterwards hit zero counters and are ignored.

## Configuration
- `ISSUE_SCOREBOARD_WB_BYPASS_EN`
  - Defined: a source whose cnt=1 is treated as clear when wb_valid && wb_register equals it in the same cycle. This saves one bubble per dependency.
  - Undefined: hazard uses the registered counters only; one extra stall cycle per RAW dependency.

## Structure
- Shared package holds:
  - `instruction_kind` (existing).
  - the `uses_of` function.
  - the register-index width constant (4) and the register count (16).
- One sub-module: `pending_counter_file`. It holds 16×PENDING_W counters, with one increment port, two decrement ports (wb, flush undo), two read ports plus a destination read port, and `any_nonzero`.

## Test plan
- Independent stream: ADD x1,x2,x3 then ADD x4,x5,x6 with execute always ready → both issued on consecutive cycles; cnt[1]=1, cnt[4]=1.
- RAW stall: ADDI x5 issued, then ADD x6,x5,x5 → decode ready=0 until wb_valid on x5; issue the next edge. With the macro, issue occurs on the same edge as wb.
- Saturation: three LUI x7 with no wb (PENDING_W=2) → fourth LUI x7 stalls. One wb x7 → accepted, cnt[7] stays 3.
- Back-pressure: to_execute.ready=0 for 5 cycles with the slot full → payload stable, from_decode.ready=0, no counter change.
- Flush: ADDI x9 in the slot, flush=1 → to_execute.valid 0 next cycle, cnt[9] returns to 0, pending_any=0.
- Reset mid-run: reset low with cnt[3]=2 and the slot full → all outputs at reset values. A later wb x3 leaves cnt[3]=0.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: instruction kinds, the issue payload,
// register-index sizing and the per-kind register usage table.
`ifndef LOG
`define LOG(msg) begin end
`endif

package issue_scoreboard_pkg;

    localparam int REG_IDX_W = 4;
    localparam int REG_COUNT = 16;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ADD  = 3'd1,
        ADDI = 3'd2,
        LUI  = 3'd3,
        LW   = 3'd4,
        SW   = 3'd5,
        BEQ  = 3'd6
    } instruction_kind;

    typedef struct packed {
        instruction_kind instruction;
        logic [4:0]      destination;
        logic [4:0]      operand_1;
        logic [4:0]      operand_2;
        logic [31:0]     immediate;
    } issue_payload_t;

    typedef struct packed {
        logic readsRs1;
        logic readsRs2;
        logic writesRd;
    } reg_use_t;

    function automatic reg_use_t uses_of(input instruction_kind kind);
        reg_use_t u;
        u = '0;
        case (kind)
            ADD:     u = '{readsRs1: 1'b1, readsRs2: 1'b1, writesRd: 1'b1};
            ADDI:    u = '{readsRs1: 1'b1, readsRs2: 1'b0, writesRd: 1'b1};
            LUI:     u = '{readsRs1: 1'b0, readsRs2: 1'b0, writesRd: 1'b1};
            LW:      u = '{readsRs1: 1'b1, readsRs2: 1'b0, writesRd: 1'b1};
            SW:      u = '{readsRs1: 1'b1, readsRs2: 1'b1, writesRd: 1'b0};
            BEQ:     u = '{readsRs1: 1'b1, readsRs2: 1'b1, writesRd: 1'b0};
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/skid_buffer_port.sv
// Valid/ready handshake carrying one issue payload; upstream is the receiving
// side of a stage, downstream the sending side.
interface skid_buffer_port;
    logic                                valid;
    logic                                ready;
    issue_scoreboard_pkg::issue_payload_t data;

    modport upstream   (input valid, input data, output ready);
    modport downstream (output valid, output data, input ready);
endinterface

// File: rtl/pending_counter_file.sv
// Per-register outstanding-write counters with one increment, two decrement
// ports, two source reads, a destination read and an any-nonzero summary.
module pending_counter_file
    import issue_scoreboard_pkg::*;
#(
    parameter int PENDING_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 incEn_i,
    input  logic [REG_IDX_W-1:0] incIdx_i,
    input  logic                 wbDecEn_i,
    input  logic [REG_IDX_W-1:0] wbDecIdx_i,
    input  logic                 undoDecEn_i,
    input  logic [REG_IDX_W-1:0] undoDecIdx_i,
    input  logic [REG_IDX_W-1:0] rdIdx1_i,
    input  logic [REG_IDX_W-1:0] rdIdx2_i,
    input  logic [REG_IDX_W-1:0] dstIdx_i,
    output logic [PENDING_W-1:0] rdCnt1_o,
    output logic [PENDING_W-1:0] rdCnt2_o,
    output logic [PENDING_W-1:0] dstCnt_o,
    output logic                 anyNonzero_o
);

    localparam int CW = PENDING_W + 1;
    localparam logic [CW-1:0] CNT_MAX_W = CW'({PENDING_W{1'b1}});

    logic [PENDING_W-1:0] cnt_q [REG_COUNT];
    logic [PENDING_W-1:0] cnt_d [REG_COUNT];

    // Net change is applied in one step so simultaneous +1/-1 cancel, and the
    // result is floored at zero so a stray decrement cannot wrap.
    function automatic logic [PENDING_W-1:0] nextCount(input logic [PENDING_W-1:0] cnt,
                                                       input logic inc,
                                                       input logic decA,
                                                       input logic decB);
        logic [CW-1:0] sum;
        logic [CW-1:0] dec;
        logic [CW-1:0] res;
        sum = CW'(cnt) + CW'(inc);
        dec = CW'(decA) + CW'(decB);
        if (dec > sum)
            res = '0;
        else
            res = sum - dec;
        if (res > CNT_MAX_W)
            res = CNT_MAX_W;
        return res[PENDING_W-1:0];
    endfunction

    always_comb begin
        anyNonzero_o = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            cnt_d[i] = '0;
            if (i != 0)
                cnt_d[i] = nextCount(cnt_q[i],
                                     incEn_i     && (incIdx_i     == REG_IDX_W'(i)),
                                     wbDecEn_i   && (wbDecIdx_i   == REG_IDX_W'(i)),
                                     undoDecEn_i && (undoDecIdx_i == REG_IDX_W'(i)));
            anyNonzero_o = anyNonzero_o | (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
            if (wbDecEn_i && (cnt_q[wbDecIdx_i] == '0))
                `LOG("issue_scoreboard: writeback retired a register with no pending write")
        end
    end

    assign rdCnt1_o = cnt_q[rdIdx1_i];
    assign rdCnt2_o = cnt_q[rdIdx2_i];
    assign dstCnt_o = cnt_q[dstIdx_i];

endmodule

// File: rtl/issue_scoreboard.sv
// Single-slot issue stage with per-register RAW/saturation stalls.
// Define ISSUE_SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback clear a source.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int PENDING_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    skid_buffer_port.upstream    from_decode,
    skid_buffer_port.downstream  to_execute,
    input  logic                 flush,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_register,
    output logic                 pending_any
);

    localparam logic [PENDING_W-1:0] CNT_MAX = '1;

    logic           slotValid_q, slotValid_d;
    issue_payload_t slotData_q,  slotData_d;

    reg_use_t             inUse, slotUse;
    logic [REG_IDX_W-1:0] rs1, rs2, rd, slotRd;
    logic [PENDING_W-1:0] rs1Cnt, rs2Cnt, rdCnt;
    logic                 rs1Bypass, rs2Bypass;
    logic                 hazard, accept, transfer;
    logic                 incEn, wbDecEn, undoDecEn, anyNonzero;

    assign inUse   = uses_of(from_decode.data.instruction);
    assign rs1     = from_decode.data.operand_1[REG_IDX_W-1:0];
    assign rs2     = from_decode.data.operand_2[REG_IDX_W-1:0];
    assign rd      = from_decode.data.destination[REG_IDX_W-1:0];
    assign slotUse = uses_of(slotData_q.instruction);
    assign slotRd  = slotData_q.destination[REG_IDX_W-1:0];

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    // A last outstanding write retiring this cycle no longer blocks its readers.
    assign rs1Bypass = wb_valid && (wb_register == rs1) && (rs1Cnt == PENDING_W'(1));
    assign rs2Bypass = wb_valid && (wb_register == rs2) && (rs2Cnt == PENDING_W'(1));
`else
    assign rs1Bypass = 1'b0;
    assign rs2Bypass = 1'b0;
`endif

    assign hazard = (inUse.readsRs1 && (rs1 != '0) && (rs1Cnt != '0) && !rs1Bypass) ||
                    (inUse.readsRs2 && (rs2 != '0) && (rs2Cnt != '0) && !rs2Bypass) ||
                    (inUse.writesRd && (rd  != '0) && (rdCnt == CNT_MAX));

    assign from_decode.ready = !hazard && !flush && (!slotValid_q || to_execute.ready);
    assign accept            = from_decode.valid && from_decode.ready;
    assign transfer          = slotValid_q && to_execute.ready;

    assign incEn     = accept && inUse.writesRd && (rd != '0);
    assign wbDecEn   = wb_valid && (wb_register != '0);
    assign undoDecEn = flush && slotValid_q && slotUse.writesRd && (slotRd != '0);

    pending_counter_file #(
        .PENDING_W (PENDING_W)
    ) u_counters (
        .clock        (clock),
        .reset        (reset),
        .incEn_i      (incEn),
        .incIdx_i     (rd),
        .wbDecEn_i    (wbDecEn),
        .wbDecIdx_i   (wb_register),
        .undoDecEn_i  (undoDecEn),
        .undoDecIdx_i (slotRd),
        .rdIdx1_i     (rs1),
        .rdIdx2_i     (rs2),
        .dstIdx_i     (rd),
        .rdCnt1_o     (rs1Cnt),
        .rdCnt2_o     (rs2Cnt),
        .dstCnt_o     (rdCnt),
        .anyNonzero_o (anyNonzero)
    );

    always_comb begin
        slotValid_d = slotValid_q;
        slotData_d  = slotData_q;
        if (flush) begin
            slotValid_d = 1'b0;
        end else if (accept) begin
            slotValid_d = 1'b1;
            slotData_d  = from_decode.data;
        end else if (transfer) begin
            slotValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slotValid_q <= 1'b0;
            slotData_q  <= '0;
        end else begin
            slotValid_q <= slotValid_d;
            slotData_q  <= slotData_d;
        end
    end

    assign to_execute.valid = slotValid_q;
    assign to_execute.data  = slotData_q;
    assign pending_any      = anyNonzero || slotValid_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus a randomized
// run against a counter/slot reference model.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int PW      = 2;
    localparam int CNT_MAX = (1 << PW) - 1;

    logic       clock;
    logic       resetN;
    logic       flushIn;
    logic       wbValid;
    logic [3:0] wbReg;
    logic       pendingAny;

    int testsRun    = 0;
    int testsFailed = 0;

    int             mCnt [16];
    bit             mValid;
    issue_payload_t mData;

    skid_buffer_port fromDecode ();
    skid_buffer_port toExecute ();

    issue_scoreboard #(
        .PENDING_W (PW)
    ) dut (
        .clock       (clock),
        .reset       (resetN),
        .from_decode (fromDecode),
        .to_execute  (toExecute),
        .flush       (flushIn),
        .wb_valid    (wbValid),
        .wb_register (wbReg),
        .pending_any (pendingAny)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    // Register usage of each kind as {reads rs1, reads rs2, writes rd}.
    function automatic bit [2:0] benchUses(instruction_kind k);
        case (k)
            ADD:     return 3'b111;
            ADDI:    return 3'b101;
            LUI:     return 3'b001;
            LW:      return 3'b101;
            SW:      return 3'b110;
            BEQ:     return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit srcBlocked(int r);
        if (r == 0 || mCnt[r] == 0) return 1'b0;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        if (mCnt[r] == 1 && wbValid && int'(wbReg) == r) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit modelReady();
        bit [2:0] u;
        int rs1, rs2, rd;
        bit hz;
        u   = benchUses(fromDecode.data.instruction);
        rs1 = int'(fromDecode.data.operand_1[3:0]);
        rs2 = int'(fromDecode.data.operand_2[3:0]);
        rd  = int'(fromDecode.data.destination[3:0]);
        hz  = (u[2] && srcBlocked(rs1)) || (u[1] && srcBlocked(rs2)) ||
              (u[0] && rd != 0 && mCnt[rd] == CNT_MAX);
        return !hz && !flushIn && (!mValid || toExecute.ready);
    endfunction

    function automatic bit modelPending();
        bit p;
        p = mValid;
        for (int i = 0; i < 16; i++) if (mCnt[i] != 0) p = 1'b1;
        return p;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 16; i++) mCnt[i] = 0;
        mValid = 1'b0;
        mData  = '0;
    endtask

    // Advance the reference model by one rising edge using the driven inputs.
    task automatic modelStep();
        int  delta [16];
        bit  acc, xfer;
        int  rd, srd;
        bit [2:0] u;
        if (!resetN) begin
            modelClear();
            return;
        end
        for (int i = 0; i < 16; i++) delta[i] = 0;
        acc  = fromDecode.valid && modelReady();
        xfer = mValid && toExecute.ready;
        u    = benchUses(fromDecode.data.instruction);
        rd   = int'(fromDecode.data.destination[3:0]);
        srd  = int'(mData.destination[3:0]);
        if (acc && u[0] && rd != 0) delta[rd] += 1;
        if (wbValid && wbReg != 0) delta[int'(wbReg)] -= 1;
        if (flushIn && mValid && benchUses(mData.instruction) != 3'b000 &&
            benchUses(mData.instruction) & 3'b001 && srd != 0) delta[srd] -= 1;
        for (int i = 0; i < 16; i++) begin
            mCnt[i] = mCnt[i] + delta[i];
            if (mCnt[i] < 0) mCnt[i] = 0;
        end
        if (flushIn)   mValid = 1'b0;
        else if (acc) begin mValid = 1'b1; mData = fromDecode.data; end
        else if (xfer) mValid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        @(negedge clock);
    endtask

    task automatic setIdle();
        fromDecode.valid = 1'b0;
        fromDecode.data  = '0;
        toExecute.ready  = 1'b1;
        flushIn          = 1'b0;
        wbValid          = 1'b0;
        wbReg            = 4'd0;
    endtask

    task automatic applyStimulus(bit dv, instruction_kind k, int rd, int rs1, int rs2);
        fromDecode.valid                = dv;
        fromDecode.data.instruction     = k;
        fromDecode.data.destination     = 5'(rd);
        fromDecode.data.operand_1       = 5'(rs1);
        fromDecode.data.operand_2       = 5'(rs2);
        fromDecode.data.immediate       = $urandom;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        setIdle();
        modelClear();
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        #1;
        testsRun++; if (toExecute.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: observed %b expected 0", toExecute.valid); end
        testsRun++; if (pendingAny !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pending: observed %b expected 0", pendingAny); end
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: observed %b expected 1", fromDecode.ready); end
    endtask

    task automatic test_independent();
        doReset();
        applyStimulus(1, ADD, 1, 2, 3); #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL indep_ready_a: observed %b expected 1", fromDecode.ready); end
        tick();
        applyStimulus(1, ADD, 4, 5, 6); #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL indep_ready_b: observed %b expected 1", fromDecode.ready); end
        testsRun++; if (toExecute.valid !== 1'b1 || toExecute.data.destination !== 5'd1) begin testsFailed++; $display("[TB] FAIL indep_issue_a: observed valid %b rd %0d expected valid 1 rd 1", toExecute.valid, toExecute.data.destination); end
        tick();
        applyStimulus(1, ADD, 7, 1, 0); #1;
        testsRun++; if (toExecute.valid !== 1'b1 || toExecute.data.destination !== 5'd4) begin testsFailed++; $display("[TB] FAIL indep_issue_b: observed valid %b rd %0d expected valid 1 rd 4", toExecute.valid, toExecute.data.destination); end
        testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL indep_x1_pending: observed ready %b expected 0", fromDecode.ready); end
        applyStimulus(1, ADD, 7, 4, 0); #1;
        testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL indep_x4_pending: observed ready %b expected 0", fromDecode.ready); end
    endtask

    task automatic test_raw_stall();
        doReset();
        applyStimulus(1, ADDI, 5, 1, 0); #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL raw_producer: observed %b expected 1", fromDecode.ready); end
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, ADD, 6, 5, 5); #1;
            testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL raw_stall%0d: observed %b expected 0", c, fromDecode.ready); end
            tick();
        end
        wbValid = 1'b1; wbReg = 4'd5; #1;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL raw_wb_edge: observed %b expected 1", fromDecode.ready); end
        tick();
        wbValid = 1'b0; fromDecode.valid = 1'b0;
`else
        testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL raw_wb_edge: observed %b expected 0", fromDecode.ready); end
        tick();
        wbValid = 1'b0; #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL raw_after_wb: observed %b expected 1", fromDecode.ready); end
        tick();
        fromDecode.valid = 1'b0;
`endif
        #1;
        testsRun++; if (toExecute.valid !== 1'b1 || toExecute.data.destination !== 5'd6) begin testsFailed++; $display("[TB] FAIL raw_issue: observed valid %b rd %0d expected valid 1 rd 6", toExecute.valid, toExecute.data.destination); end
    endtask

    task automatic test_saturation();
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, LUI, 7, 0, 0); #1;
            testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_fill%0d: observed %b expected 1", c, fromDecode.ready); end
            tick();
        end
        applyStimulus(1, LUI, 7, 0, 0); #1;
        testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_full: observed %b expected 0", fromDecode.ready); end
        wbValid = 1'b1; wbReg = 4'd7; #1;
        testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_wb_edge: observed %b expected 0", fromDecode.ready); end
        tick();
        wbValid = 1'b0; #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_after_wb: observed %b expected 1", fromDecode.ready); end
        tick();
        applyStimulus(1, LUI, 7, 0, 0); #1;
        testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_refull: observed %b expected 0", fromDecode.ready); end
    endtask

    task automatic test_back_pressure();
        issue_payload_t held;
        doReset();
        toExecute.ready = 1'b0;
        applyStimulus(1, ADD, 1, 2, 3); #1;
        held = fromDecode.data;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_accept: observed %b expected 1", fromDecode.ready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, ADD, 4, 5, 6); #1;
            testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_ready%0d: observed %b expected 0", c, fromDecode.ready); end
            testsRun++; if (toExecute.valid !== 1'b1 || toExecute.data !== held) begin testsFailed++; $display("[TB] FAIL bp_payload%0d: observed %h expected %h", c, toExecute.data, held); end
            tick();
        end
        toExecute.ready = 1'b1; #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_release: observed %b expected 1", fromDecode.ready); end
        tick();
        wbValid = 1'b1; wbReg = 4'd1; fromDecode.valid = 1'b0;
        tick();
        wbValid = 1'b0;
        applyStimulus(1, ADD, 8, 1, 0); #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_single_count: observed %b expected 1", fromDecode.ready); end
    endtask

    task automatic test_flush();
        doReset();
        toExecute.ready = 1'b0;
        applyStimulus(1, ADDI, 9, 1, 0); #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_accept: observed %b expected 1", fromDecode.ready); end
        tick();
        flushIn = 1'b1;
        applyStimulus(1, ADD, 2, 3, 4); #1;
        testsRun++; if (fromDecode.ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_ready: observed %b expected 0", fromDecode.ready); end
        tick();
        flushIn = 1'b0; fromDecode.valid = 1'b0; #1;
        testsRun++; if (toExecute.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_valid: observed %b expected 0", toExecute.valid); end
        testsRun++; if (pendingAny !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_pending: observed %b expected 0", pendingAny); end
        applyStimulus(1, ADDI, 10, 9, 0); #1;
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_x9_clear: observed %b expected 1", fromDecode.ready); end
    endtask

    task automatic test_reset_mid();
        doReset();
        applyStimulus(1, LUI, 3, 0, 0); tick();
        applyStimulus(1, LUI, 3, 0, 0); tick();
        toExecute.ready = 1'b0; fromDecode.valid = 1'b0; #1;
        testsRun++; if (toExecute.valid !== 1'b1 || pendingAny !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmid_before: observed valid %b pending %b expected 1 1", toExecute.valid, pendingAny); end
        #1 resetN = 1'b0; #1;
        testsRun++; if (toExecute.valid !== 1'b0 || pendingAny !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_clear: observed valid %b pending %b expected 0 0", toExecute.valid, pendingAny); end
        testsRun++; if (fromDecode.ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmid_ready: observed %b expected 1", fromDecode.ready); end
        @(negedge clock);
        resetN = 1'b1; modelClear();
        wbValid = 1'b1; wbReg = 4'd3;
        tick();
        wbValid = 1'b0;
        applyStimulus(1, ADD, 4, 3, 3); #1;
        testsRun++; if (fromDecode.ready !== 1'b1 || pendingAny !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_late_wb: observed ready %b pending %b expected 1 0", fromDecode.ready, pendingAny); end
    endtask

    task automatic test_random();
        bit expReady, expPend;
        doReset();
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, instruction_kind'($urandom_range(0, 6)),
                          int'($urandom_range(0, 5)) + 16 * int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            toExecute.ready = ($urandom_range(0, 4) != 0);
            flushIn         = ($urandom_range(0, 19) == 0);
            wbValid         = ($urandom_range(0, 2) == 0);
            wbReg           = 4'($urandom_range(0, 5));
            #1;
            expReady = modelReady();
            expPend  = modelPending();
            testsRun++; if (fromDecode.ready !== expReady) begin testsFailed++; $display("[TB] FAIL rand_ready@%0d: observed %b expected %b", c, fromDecode.ready, expReady); end
            testsRun++; if (toExecute.valid !== mValid) begin testsFailed++; $display("[TB] FAIL rand_valid@%0d: observed %b expected %b", c, toExecute.valid, mValid); end
            testsRun++; if (pendingAny !== expPend) begin testsFailed++; $display("[TB] FAIL rand_pending@%0d: observed %b expected %b", c, pendingAny, expPend); end
            if (mValid) begin
                testsRun++; if (toExecute.data !== mData) begin testsFailed++; $display("[TB] FAIL rand_data@%0d: observed %h expected %h", c, toExecute.data, mData); end
            end
            tick();
        end
    endtask

    initial begin
        resetN = 1'b0;
        setIdle();
        modelClear();
        test_reset();
        test_independent();
        test_raw_stall();
        test_saturation();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
